// File: rtl/smi_pkg.sv
// Shared types for the SMI I/Q byte packer: frame states, sync patterns and the word-to-byte map.
package smi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_B0,
        S_B1,
        S_B2,
        S_B3
    } state_e;

    localparam logic [1:0] I_SYNC = 2'b10;
    localparam logic [1:0] Q_SYNC = 2'b01;

    // Returns {b0,b1,b2,b3}; b0 alone carries MSB=1 so the consumer can find frame starts.
    function automatic logic [31:0] word_to_bytes(input logic [31:0] w);
        return {1'b1, w[16], w[0], w[29:25],
                1'b0, w[24:18],
                1'b0, w[17], w[13:8],
                1'b0, w[7:1]};
    endfunction

    function automatic logic sync_ok(input logic [31:0] w);
        return (w[31:30] == I_SYNC) && (w[15:14] == Q_SYNC);
    endfunction

endpackage

// File: rtl/smi_iq_byte_packer.sv
// Packs 32-bit RX I/Q words into 4-byte SMI frames with a one-word prefetch.
// Optional SMI_PACKER_TEST_PATTERN_EN adds i_test_mode, replacing FIFO words with a counting pattern.
module smi_iq_byte_packer
    import smi_pkg::*;
#(
    parameter int ERR_CNT_W     = 8,
    parameter bit DROP_BAD_SYNC = 1'b1
) (
    input  logic                 i_sys_clk,
    input  logic                 i_rst,
    input  logic                 i_enable,
    input  logic                 i_fifo_empty,
    output logic                 o_fifo_pull,
    input  logic [31:0]          i_fifo_data,
    output logic [7:0]           o_byte,
    output logic                 o_byte_valid,
    input  logic                 i_byte_ready,
    output logic                 o_word_start,
    output logic                 o_busy,
`ifdef SMI_PACKER_TEST_PATTERN_EN
    input  logic                 i_test_mode,
`endif
    output logic [ERR_CNT_W-1:0] o_sync_err_cnt
);

    state_e                 state_q, state_d;
    logic                   pull_q, pull_d;
    logic                   cap_q;
    logic                   next_valid_q, next_valid_d;
    logic [31:0]            next_q, next_d;
    logic [31:0]            cur_q, cur_d;
    logic [7:0]             byte_q, byte_d;
    logic [ERR_CNT_W-1:0]   err_q, err_d;

    logic                   in_valid;
    logic [31:0]            in_word;
    logic                   in_ok;
    logic                   in_keep;
    logic                   accept;
    logic                   have_word;
    logic                   load;
    logic [31:0]            load_word;
    logic [31:0]            frame_bytes;
    logic                   pull_allowed;

`ifdef SMI_PACKER_TEST_PATTERN_EN
    logic [12:0]            pat_cnt_q;
    logic                   gen_cap;

    // Pattern words appear whenever the prefetch slot is free and no FIFO read is still in flight.
    assign gen_cap      = i_test_mode & i_enable & ~next_valid_q & ~pull_q & ~cap_q;
    assign in_valid     = cap_q | gen_cap;
    assign in_word      = cap_q ? i_fifo_data
                                : {I_SYNC, pat_cnt_q, 1'b0, Q_SYNC, ~pat_cnt_q, 1'b0};
    assign pull_allowed = ~i_test_mode;

    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            pat_cnt_q <= '0;
        end else if (gen_cap) begin
            pat_cnt_q <= pat_cnt_q + 13'd1;
        end
    end
`else
    assign in_valid     = cap_q;
    assign in_word      = i_fifo_data;
    assign pull_allowed = 1'b1;
`endif

    assign in_ok     = sync_ok(in_word);
    assign in_keep   = in_valid & (in_ok | ~DROP_BAD_SYNC);
    assign accept    = (state_q != S_IDLE) & i_byte_ready;
    assign have_word = next_valid_q | in_keep;
    // A word arriving on the frame boundary bypasses the prefetch slot so frames run back-to-back.
    assign load      = ((state_q == S_IDLE) | ((state_q == S_B3) & accept)) & have_word;
    assign load_word = next_valid_q ? next_q : in_word;

    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            pull_q       <= 1'b0;
            cap_q        <= 1'b0;
            next_valid_q <= 1'b0;
            next_q       <= '0;
            cur_q        <= '0;
            byte_q       <= '0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            pull_q       <= pull_d;
            cap_q        <= pull_q;
            next_valid_q <= next_valid_d;
            next_q       <= next_d;
            cur_q        <= cur_d;
            byte_q       <= byte_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (have_word) state_d = S_B0;
            S_B0:    if (accept)    state_d = S_B1;
            S_B1:    if (accept)    state_d = S_B2;
            S_B2:    if (accept)    state_d = S_B3;
            S_B3:    if (accept)    state_d = have_word ? S_B0 : S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pull_d       = i_enable & ~i_fifo_empty & ~next_valid_q & ~pull_q & ~cap_q & pull_allowed;
        cur_d        = load ? load_word : cur_q;
        next_d       = next_q;
        next_valid_d = next_valid_q;
        if (load && next_valid_q) begin
            next_valid_d = 1'b0;
        end
        if (in_keep && !(load && !next_valid_q)) begin
            next_d       = in_word;
            next_valid_d = 1'b1;
        end
        err_d = err_q;
        if (in_valid && !in_ok && (err_q != {ERR_CNT_W{1'b1}})) begin
            err_d = err_q + 1'b1;
        end
    end

    always_comb begin
        frame_bytes = word_to_bytes(load ? load_word : cur_q);
        byte_d      = 8'h00;
        unique case (state_d)
            S_B0:    byte_d = frame_bytes[31:24];
            S_B1:    byte_d = frame_bytes[23:16];
            S_B2:    byte_d = frame_bytes[15:8];
            S_B3:    byte_d = frame_bytes[7:0];
            default: byte_d = 8'h00;
        endcase
    end

    assign o_fifo_pull    = pull_q;
    assign o_byte         = byte_q;
    assign o_byte_valid   = (state_q != S_IDLE);
    assign o_word_start   = (state_q == S_B0);
    assign o_busy         = (state_q != S_IDLE) | next_valid_q | pull_q | cap_q;
    assign o_sync_err_cnt = err_q;

endmodule

// File: tb/tb_smi_iq_byte_packer.sv
// Directed bench for smi_iq_byte_packer: a registered-read FIFO model feeds words, bytes are checked at negedges.
module tb_smi_iq_byte_packer;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        byteReady;
    logic        fifoEmpty;
    logic        fifoPull;
    logic [31:0] fifoData = 32'h0;
    logic [7:0]  byteOut;
    logic        byteValid;
    logic        wordStart;
    logic        busy;
    logic [7:0]  errCnt;

    logic [31:0] fifoMem [0:1023];
    int          wrPtr = 0;
    int          rdPtr = 0;
    int          checks = 0;
    int          failures = 0;
    logic [7:0]  expB [4];
    logic        sawValid;
    logic        sawPull;
    int          n;

    smi_iq_byte_packer dut (
        .i_sys_clk      (clock),
        .i_rst          (reset),
        .i_enable       (enable),
        .i_fifo_empty   (fifoEmpty),
        .o_fifo_pull    (fifoPull),
        .i_fifo_data    (fifoData),
        .o_byte         (byteOut),
        .o_byte_valid   (byteValid),
        .i_byte_ready   (byteReady),
        .o_word_start   (wordStart),
        .o_busy         (busy),
`ifdef SMI_PACKER_TEST_PATTERN_EN
        .i_test_mode    (1'b0),
`endif
        .o_sync_err_cnt (errCnt)
    );

    always #5 clock = ~clock;

    // Registered-read FIFO: data appears the cycle after the pull strobe.
    assign fifoEmpty = (rdPtr == wrPtr);
    always @(posedge clock) begin
        if (fifoPull && (rdPtr < wrPtr)) begin
            fifoData <= fifoMem[rdPtr];
            rdPtr    <= rdPtr + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] word, input int count);
        for (int i = 0; i < count; i++) begin
            fifoMem[wrPtr] = word;
            wrPtr = wrPtr + 1;
        end
    endtask

    task automatic waitValid(input string tag);
        int k = 0;
        while (!byteValid && k < 20) begin
            @(negedge clock);
            k++;
        end
        checkOutput(tag, {31'b0, byteValid}, 32'd1);
    endtask

    initial begin
        expB = '{8'h8F, 8'h16, 8'h7F, 8'h1E};
        reset     = 1'b1;
        enable    = 1'b0;
        byteReady = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("rst_valid", {31'b0, byteValid}, 32'd0);
        checkOutput("rst_byte",  {24'b0, byteOut},   32'd0);
        checkOutput("rst_start", {31'b0, wordStart}, 32'd0);
        checkOutput("rst_busy",  {31'b0, busy},      32'd0);
        checkOutput("rst_pull",  {31'b0, fifoPull},  32'd0);
        checkOutput("rst_err",   {24'b0, errCnt},    32'd0);

        // Single good word: exact latency and byte map.
        $display("[TB] single frame");
        applyStimulus(32'h9E5A7F3C, 1);
        enable = 1'b1;
        @(negedge clock);
        checkOutput("t1_pull_c0", {31'b0, fifoPull}, 32'd1);
        checkOutput("t1_busy",    {31'b0, busy},     32'd1);
        @(negedge clock);
        checkOutput("t1_valid_c1", {31'b0, byteValid}, 32'd0);
        checkOutput("t1_pull_c1",  {31'b0, fifoPull},  32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checkOutput("t1_valid", {31'b0, byteValid}, 32'd1);
            checkOutput("t1_byte",  {24'b0, byteOut},   {24'b0, expB[i]});
            checkOutput("t1_start", {31'b0, wordStart}, (i == 0) ? 32'd1 : 32'd0);
        end
        @(negedge clock);
        checkOutput("t1_idle_valid", {31'b0, byteValid}, 32'd0);
        checkOutput("t1_idle_busy",  {31'b0, busy},      32'd0);

        // Two words back-to-back: eight consecutive bytes.
        $display("[TB] back-to-back frames");
        applyStimulus(32'h9E5A7F3C, 2);
        waitValid("t2_first_valid");
        for (int i = 0; i < 8; i++) begin
            checkOutput("t2_valid", {31'b0, byteValid}, 32'd1);
            checkOutput("t2_byte",  {24'b0, byteOut},   {24'b0, expB[i % 4]});
            @(negedge clock);
        end
        checkOutput("t2_end_valid", {31'b0, byteValid}, 32'd0);

        // Bad sync words are dropped and counted, saturating at all-ones.
        $display("[TB] bad sync");
        applyStimulus(32'h1E5A7F3C, 1);
        sawValid = 1'b0;
        repeat (8) begin
            @(negedge clock);
            sawValid = sawValid | byteValid;
        end
        checkOutput("t3_err_one", {24'b0, errCnt}, 32'd1);
        applyStimulus(32'h1E5A7F3C, 300);
        n = 0;
        while (!(rdPtr == wrPtr && !busy) && n < 3000) begin
            @(negedge clock);
            sawValid = sawValid | byteValid;
            n++;
        end
        checkOutput("t3_drained",  {31'b0, (rdPtr == wrPtr && !busy)}, 32'd1);
        checkOutput("t3_no_bytes", {31'b0, sawValid}, 32'd0);
        checkOutput("t3_err_sat",  {24'b0, errCnt},   32'hFF);

        // Stalls: bytes hold while ready is low.
        $display("[TB] ready toggling");
        byteReady = 1'b0;
        applyStimulus(32'h9E5A7F3C, 1);
        waitValid("t4_valid");
        for (int i = 0; i < 4; i++) begin
            checkOutput("t4_byte",       {24'b0, byteOut}, {24'b0, expB[i]});
            @(negedge clock);
            checkOutput("t4_byte_stall", {24'b0, byteOut}, {24'b0, expB[i]});
            byteReady = 1'b1;
            @(negedge clock);
            byteReady = 1'b0;
        end
        checkOutput("t4_end_valid", {31'b0, byteValid}, 32'd0);
        byteReady = 1'b1;

        // Enable drops mid-frame: current and prefetched frames drain, no new pulls.
        $display("[TB] enable drop");
        applyStimulus(32'h9E5A7F3C, 3);
        waitValid("t5_valid");
        checkOutput("t5_b0", {24'b0, byteOut}, 32'h8F);
        @(negedge clock);
        checkOutput("t5_b1", {24'b0, byteOut}, 32'h16);
        @(negedge clock);
        checkOutput("t5_b2", {24'b0, byteOut}, 32'h7F);
        enable  = 1'b0;
        sawPull = 1'b0;
        for (int i = 3; i < 8; i++) begin
            @(negedge clock);
            sawPull = sawPull | fifoPull;
            checkOutput("t5_drain", {24'b0, byteOut}, {24'b0, expB[i % 4]});
        end
        @(negedge clock);
        checkOutput("t5_end_valid", {31'b0, byteValid}, 32'd0);
        repeat (6) begin
            @(negedge clock);
            sawPull = sawPull | fifoPull;
        end
        checkOutput("t5_no_pull",   {31'b0, sawPull}, 32'd0);
        checkOutput("t5_fifo_left", wrPtr - rdPtr,    32'd1);

        // Reset mid-frame abandons it; the next frame starts cleanly at byte0.
        $display("[TB] reset mid-frame");
        enable = 1'b1;
        waitValid("t6_valid");
        checkOutput("t6_b0", {24'b0, byteOut}, 32'h8F);
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        checkOutput("t6_b3", {24'b0, byteOut}, 32'h1E);
        reset = 1'b1;
        #1;
        checkOutput("t6_rst_valid", {31'b0, byteValid}, 32'd0);
        checkOutput("t6_rst_err",   {24'b0, errCnt},    32'd0);
        checkOutput("t6_rst_busy",  {31'b0, busy},      32'd0);
        @(negedge clock);
        reset = 1'b0;
        applyStimulus(32'h9E5A7F3C, 1);
        waitValid("t6_new_valid");
        checkOutput("t6_new_b0",    {24'b0, byteOut},   32'h8F);
        checkOutput("t6_new_start", {31'b0, wordStart}, 32'd1);
        @(negedge clock);
        checkOutput("t6_new_b1",    {24'b0, byteOut},   32'h16);
        repeat (4) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
